// File: rtl/alu_pkg.sv
// Shared definitions for the ALU BIST sequencer: select codes, directed operand
// table, MISR polynomial/seed and the sequencer state type.
package alu_pkg;

    localparam logic [4:0] SEL_ADD  = 5'b00000;
    localparam logic [4:0] SEL_SLL  = 5'b00001;
    localparam logic [4:0] SEL_SLT  = 5'b00010;
    localparam logic [4:0] SEL_SLTU = 5'b00011;
    localparam logic [4:0] SEL_XOR  = 5'b00100;
    localparam logic [4:0] SEL_SRL  = 5'b00101;
    localparam logic [4:0] SEL_OR   = 5'b00110;
    localparam logic [4:0] SEL_AND  = 5'b00111;
    localparam logic [4:0] SEL_SUB  = 5'b10000;
    localparam logic [4:0] SEL_SRA  = 5'b10101;
    localparam logic [4:0] SEL_LUI  = 5'b01000;

    localparam int unsigned N_SELS      = 11;
    localparam int unsigned N_DIR_PAIRS = 5;

    localparam logic [31:0] MISR_POLY = 32'h0040_0007;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } bist_state_t;

    // Select list, swept in this order for every operand pair.
    function automatic logic [4:0] sel_code(input logic [3:0] idx);
        logic [4:0] code;
        case (idx)
            4'd0:    code = SEL_ADD;
            4'd1:    code = SEL_SLL;
            4'd2:    code = SEL_SLT;
            4'd3:    code = SEL_SLTU;
            4'd4:    code = SEL_XOR;
            4'd5:    code = SEL_SRL;
            4'd6:    code = SEL_OR;
            4'd7:    code = SEL_AND;
            4'd8:    code = SEL_SUB;
            4'd9:    code = SEL_SRA;
            4'd10:   code = SEL_LUI;
            default: code = SEL_ADD;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] dir_a(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0:    v = 32'h0000_000F;
            3'd1:    v = 32'hF000_000F;
            3'd2:    v = 32'h0123_4567;
            3'd3:    v = 32'h0000_0000;
            3'd4:    v = 32'hFFFF_FFFF;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] dir_b(input logic [2:0] idx);
        logic [31:0] v;
        case (idx)
            3'd0:    v = 32'h0000_0003;
            3'd1:    v = 32'h0000_0003;
            3'd2:    v = 32'h89AB_CDEF;
            3'd3:    v = 32'h0000_0000;
            3'd4:    v = 32'hFFFF_FFFF;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Galois step for x^32+x^22+x^2+x+1 with result/zero-flag injection.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] f,
                                              input logic        z);
        return ({sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : '0)) ^ f ^ {31'b0, z};
    endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit MISR register built on the shared Galois step; with data tied to zero
// it doubles as the operand LFSR.
module misr32
    import alu_pkg::*;
#(
    parameter logic [31:0] RST_VAL = MISR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        en,
    input  logic [31:0] f,
    input  logic        z,
    output logic [31:0] sig,
    output logic [31:0] sig_next
);

    assign sig_next = misr_step(sig, f, z);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= RST_VAL;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU BIST sequencer: drives a directed then pseudo-random operand/select sweep
// into the ALU, compacts f/z into a MISR and compares against a golden signature.
module alu_bist_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned N_RAND    = 16,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
    parameter logic [31:0] EXP_SIG   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_f,
    input  logic        alu_z,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature
);

    localparam int unsigned   NP        = N_DIR_PAIRS + N_RAND;
    localparam int unsigned   PW        = $clog2(NP);
    localparam logic [PW-1:0] LAST_PAIR = PW'(NP - 1);
    localparam logic [PW-1:0] FIRST_RND = PW'(N_DIR_PAIRS);
    localparam logic [3:0]    LAST_SEL  = 4'(N_SELS - 1);

    bist_state_t   state, state_next;
    logic [3:0]    sel_idx, sel_idx_nx;
    logic [PW-1:0] pair_idx, pair_idx_nx;
    logic          sel_wrap, last_vec;
    logic          accept, advance, run_end, abort_run;
    logic          misr_en, lfsr_en;
    logic [31:0]   misr_next, lfsr_sig, lfsr_next;

    assign sel_wrap    = (sel_idx == LAST_SEL);
    assign sel_idx_nx  = sel_wrap ? '0 : sel_idx + 4'd1;
    assign pair_idx_nx = sel_wrap ? pair_idx + PW'(1) : pair_idx;
    assign last_vec    = sel_wrap && (pair_idx == LAST_PAIR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        run_end    = 1'b0;
        abort_run  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_RUN;
                    accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    abort_run  = 1'b1;
                end else if (last_vec) begin
                    state_next = ST_DONE;
                    run_end    = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // The LFSR steps twice per random pair: once as the pair is driven (a=S,
    // b=step(S) taken combinationally) and once on the pair's next vector.
    assign misr_en = advance || run_end;
    assign lfsr_en = advance &&
                     (((sel_idx_nx == '0) && (pair_idx_nx >= FIRST_RND)) ||
                      ((sel_idx == '0) && (pair_idx >= FIRST_RND)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_idx  <= '0;
            pair_idx <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            pass     <= 1'b0;
        end else if (accept) begin
            sel_idx  <= '0;
            pair_idx <= '0;
            alu_a    <= dir_a(3'd0);
            alu_b    <= dir_b(3'd0);
            alu_sel  <= sel_code(4'd0);
            pass     <= 1'b0;
        end else if (advance) begin
            sel_idx  <= sel_idx_nx;
            pair_idx <= pair_idx_nx;
            alu_sel  <= sel_code(sel_idx_nx);
            if (sel_idx_nx == '0) begin
                if (pair_idx_nx < FIRST_RND) begin
                    alu_a <= dir_a(pair_idx_nx[2:0]);
                    alu_b <= dir_b(pair_idx_nx[2:0]);
                end else begin
                    alu_a <= lfsr_sig;
                    alu_b <= lfsr_next;
                end
            end
        end else if (run_end || abort_run) begin
            sel_idx  <= '0;
            pair_idx <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            pass     <= run_end && (misr_next == EXP_SIG);
        end
    end

    misr32 #(.RST_VAL(MISR_SEED)) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .seed     (MISR_SEED),
        .en       (misr_en),
        .f        (alu_f),
        .z        (alu_z),
        .sig      (signature),
        .sig_next (misr_next)
    );

    misr32 #(.RST_VAL('0)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .seed     (LFSR_SEED),
        .en       (lfsr_en),
        .f        ('0),
        .z        (1'b0),
        .sig      (lfsr_sig),
        .sig_next (lfsr_next)
    );

endmodule

// File: doc/alu_bist_ctrl.md
# alu_bist_ctrl

Built-in self-test sequencer for the RISC-V ALU. It drives the ALU's `a`, `b` and `sel` inputs through a fixed directed operand/select sweep, then an optional pseudo-random sweep. It compacts every `f`/`z` result into a 32-bit MISR signature and compares the final signature against a parameterised golden value. It sits beside the ALU behind a test mux and is the driving and observing end of the ALU operand/result interface.

## Interface
- `N_RAND`, default 16: number of pseudo-random operand pairs after the directed pairs (0 allowed).
- `LFSR_SEED`, default 32'h0000_0001: operand LFSR seed; must be nonzero.
- `EXP_SIG`, default 32'h0000_0000: golden signature; set per build from the model.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: level; begin a run when sampled high in IDLE.
- `abort` in 1: level; cancel a run; priority over `start`.
- `alu_a` out 32: ALU operand a, registered.
- `alu_b` out 32: ALU operand b, registered.
- `alu_sel` out 5: ALU select, registered.
- `alu_f` in 32: ALU result, combinational from `alu_a/alu_b/alu_sel`.
- `alu_z` in 1: ALU zero flag.
- `busy` out 1: high while vectors are applied.
- `done` out 1: one-cycle pulse at normal completion.
- `pass` out 1: `signature == EXP_SIG` after a completed run; held until the next start.
- `signature` out 32: current MISR value.

## Operation
- Select list, in order, 11 codes: 0,1,2,3,4,5,6,7, 5'b10000, 5'b10101, 5'b01000.
- Directed pairs (a,b), in order:
  - (0000000F,00000003)
  - (F000000F,00000003)
  - (01234567,89ABCDEF)
  - (00000000,00000000)
  - (FFFFFFFF,FFFFFFFF)
- Random pairs follow. LFSR steps use the same Galois step as the MISR, without data XOR.
  - a = current LFSR state.
  - b = state after one step.
  - LFSR advances two steps per pair.
  - LFSR loads `LFSR_SEED` at run start.
- Sweep order: outer loop over pairs, inner loop over all 11 selects.
- Total vectors V = (5+N_RAND)*11.
- MISR step (poly x^32+x^22+x^2+x+1):
  - sig' = ({sig[30:0],0} ^ (sig[31] ? 32'h0040_0007 : 0)) ^ f ^ {31'b0,z}.
  - Seed 32'hFFFF_FFFF, loaded at run start.
- FSM states:
  - IDLE → RUN on `start & ~abort`.
  - RUN → DONE after the last vector is absorbed.
  - RUN → IDLE on `abort`.
  - DONE → IDLE unconditionally.
- `start` in RUN or DONE is ignored.
- Abort: `done` is not pulsed, `pass`=0, `signature` holds its last value, ALU outputs return to 0.

## Timing
- Reset values: `alu_a`=0, `alu_b`=0, `alu_sel`=0, `busy`=0, `done`=0, `pass`=0, `signature`=FFFF_FFFF, state IDLE. Internal indices and the LFSR are cleared.
- Reset mid-run: all outputs take reset values on the next edge; no done pulse.
- Edge where `start` is sampled in IDLE:
  - MISR loads its seed and `pass` clears.
  - Vector 0 appears on the ALU outputs; `busy`=1 in the following cycle.
- Each RUN cycle holds vector i stable. At the closing edge, the MISR absorbs `alu_f/alu_z` for vector i and vector i+1 is driven.
- Throughput: one vector per cycle; `busy` high for exactly V cycles.
- Cycle V+1 after start (DONE):
  - `busy`=0, `done`=1, ALU outputs 0.
  - `pass` is valid and holds through IDLE until the next accepted start.
- `abort` and the last-vector edge together: abort wins, no done pulse.
- Select index wraps 10→0 with a pair-index increment. Random pair index wraps only at end of run.

## Structure
- Shared package `alu_pkg`:
  - select-code constants and 11-entry select list;
  - directed operand table;
  - MISR polynomial and seed constants;
  - FSM state enum.
- Sub-module `misr32`: shared step function. Controls `load`, `en`, and data in (`f`, `z`). Instantiated twice:
  - once as the MISR;
  - once with data tied to 0 as the operand LFSR.

## Test plan
- N_RAND=0, start pulsed one cycle:
  - first RUN cycle: `alu_a`=0000000F, `alu_b`=00000003, `alu_sel`=0;
  - 9th cycle: `alu_sel`=10000; 11th cycle: 01000;
  - 12th cycle: `alu_a`=F000000F, `alu_sel`=0;
  - `busy` exactly 55 cycles, `done` in cycle 56.
- MISR unit check: seed, one step with f=0, z=0 → FFBF_FFF9. One step with f=0, z=1 → FFBF_FFF8.
- Real ALU, EXP_SIG from model, N_RAND=16: busy 231 cycles, `pass`=1, `signature`==EXP_SIG.
- Fault injection: ALU wrapper flips f[0] when sel=5 → `pass`=0 and `signature`≠EXP_SIG.
- Abort at RUN cycle 20 (same cycle as `start` re-assertion):
  - `busy` falls next edge, no `done`, `pass`=0, `signature` frozen;
  - a later start reruns and passes.
- `rst_n` low at RUN cycle 30 → all outputs at reset values next edge; `start` in DONE ignored.
